alu_operand_dispatch: RTL and testbench
=======================================

// Module: alu_operand_dispatch
// PURPOSE
//  Execute-side pipeline stage directly upstream of the ALU. Accepts decoded ops with register values and immediate,
//  resolves operand forwarding and rs2/imm selection, then registers and presents input_a/input_b/operation to the ALU.
//  Uses a valid/ready handshake on both sides, so it absorbs backpressure from the ALU/EX-MEM side without losing ops.
// PARAMETERS
//  WORDSIZE  64  operand/result width in bits
//  REGADDR   5   register-index width
// PORTS
//  clock         in   1         rising-edge clock
//  reset_n       in   1         asynchronous active-low reset
//  flush         in   1         synchronous pipeline kill
//  in_valid      in   1         upstream op valid
//  in_ready      out  1         stage can accept op this cycle
//  in_rs1_val    in   WORDSIZE  register-file value for rs1
//  in_rs2_val    in   WORDSIZE  register-file value for rs2
//  in_imm        in   WORDSIZE  sign-extended immediate
//  in_rs1_addr   in   REGADDR   rs1 index
//  in_rs2_addr   in   REGADDR   rs2 index
//  in_rd_addr    in   REGADDR   destination index, passed through
//  in_use_imm    in   1         1: operand B = in_imm
//  in_operation  in   3         ALU opcode (000 add, 001 sub, ...)
//  fwd_ex_valid  in   1         EX/MEM result forwarding valid
//  fwd_ex_rd     in   REGADDR   EX/MEM destination
//  fwd_ex_data   in   WORDSIZE  EX/MEM result
//  fwd_wb_valid  in   1         MEM/WB writeback valid
//  fwd_wb_rd     in   REGADDR   MEM/WB destination
//  fwd_wb_data   in   WORDSIZE  MEM/WB data
//  out_valid     out  1         input_a/input_b/operation valid
//  out_ready     in   1         downstream consumes op
//  input_a       out  WORDSIZE  ALU operand A
//  input_b       out  WORDSIZE  ALU operand B
//  operation     out  3         ALU opcode
//  out_rd_addr   out  REGADDR   destination index for the result
// BEHAVIOUR
//  - Reset (async, reset_n=0): out_valid=0, input_a=input_b=0, operation=3'b000, out_rd_addr=0, all entries empty;
//    in_ready=0 while reset_n=0. Reset asserted mid-transfer drops the op; no partial state survives.
//  - Accept: in_valid&&in_ready at edge. Issue: out_valid&&out_ready at edge. Single-cycle latency accept->out_valid.
//  - Forwarding per register operand: rd==0 never forwarded; fwd_ex match beats fwd_wb match beats rf value.
//    B with in_use_imm=1 takes in_imm and is never forwarded/snooped.
//  - Snooping: every held entry compares stored rs1/rs2 against both fwd buses each cycle; same priority rules; updates in place.
//  - Ordering strictly FIFO; no op dropped/duplicated except on flush/reset.
//  - flush=1: all entries invalid at next edge, same-cycle accept ignored, out_valid=0 next cycle; flush overrides handshakes.
//  - Output registers hold their last values when out_valid=0 (no X, no clearing besides reset).
// CONFIGURATION
//  ALU_DISPATCH_SKID_EN defined: two entries (output + skid); in_ready is registered = !skid_valid; full throughput
//    under stalls; accept while output stalled fills skid; skid moves to output on issue.
//  Not defined: single entry; in_ready = !out_valid || out_ready (combinational); no skid storage.
// STRUCTURE
//  Shared package riscv_alu_pkg: ALU opcode constants (ALU_ADD=3'b000, ALU_SUB=3'b001, ...), WORDSIZE/REGADDR defaults.
//  Sub-module operand_fwd_mux: combinational forwarding/priority select, instantiated for A, B and for snoop paths.
//  Top holds the entry registers, handshake control and flush/reset logic.
// TESTING
//  1. Reset: reset_n=0 while out_valid=1 -> out_valid=0, input_a=0, operation=000 immediately; in_ready=1 after release.
//  2. rs1_val=5, rs2_val=2, op=000, no fwd, out_ready=1 -> next cycle out_valid=1, input_a=5, input_b=2, operation=000.
//  3. use_imm=1, imm=0x10, fwd_ex rd=rs2_addr -> input_b=0x10 (imm wins, no forwarding).
//  4. rs1_addr=3, fwd_ex rd=3 data=0xAA, fwd_wb rd=3 data=0xBB -> input_a=0xAA; rs1_addr=0 with fwd rd=0 -> rf value.
//  5. out_ready=0 3 cycles, push ops X,Y (SKID_EN) -> in_ready=0 after Y; fwd_wb rd=Y.rs2 data=0x77 updates held Y;
//     release -> X then Y(input_b=0x77), in order.
//  6. Both entries full + in_valid + flush=1 -> next cycle out_valid=0, in_ready=1, nothing issued afterwards.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared ALU definitions: opcode encodings and default datapath widths
// used by the operand dispatch stage and its forwarding muxes.
package riscv_alu_pkg;

    localparam int DEF_WORDSIZE = 64;
    localparam int DEF_REGADDR  = 5;
    localparam int ALU_OP_W     = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational operand resolver: immediate, then EX/MEM forward, then MEM/WB
// forward, then the supplied base value. Register x0 is never forwarded.
module operand_fwd_mux #(
    parameter int WORDSIZE = 64,
    parameter int REGADDR  = 5
) (
    input  logic [REGADDR-1:0]  i_addr,
    input  logic [WORDSIZE-1:0] i_rf_val,
    input  logic                i_use_imm,
    input  logic [WORDSIZE-1:0] i_imm,
    input  logic                i_ex_valid,
    input  logic [REGADDR-1:0]  i_ex_rd,
    input  logic [WORDSIZE-1:0] i_ex_data,
    input  logic                i_wb_valid,
    input  logic [REGADDR-1:0]  i_wb_rd,
    input  logic [WORDSIZE-1:0] i_wb_data,
    output logic [WORDSIZE-1:0] o_value
);

    logic w_nonzero;
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_nonzero = (i_addr != '0);
    assign w_ex_hit  = w_nonzero && i_ex_valid && (i_ex_rd == i_addr);
    assign w_wb_hit  = w_nonzero && i_wb_valid && (i_wb_rd == i_addr);

    always_comb begin
        o_value = i_rf_val;
        if (i_use_imm) begin
            o_value = i_imm;
        end else if (w_ex_hit) begin
            o_value = i_ex_data;
        end else if (w_wb_hit) begin
            o_value = i_wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_dispatch.sv
// Pipeline stage in front of the ALU: resolves forwarding, registers operands and
// handshakes both sides. Define ALU_DISPATCH_SKID_EN for a two-entry (output + skid) build.
module alu_operand_dispatch
    import riscv_alu_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int REGADDR  = DEF_REGADDR
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] in_rs1_val,
    input  logic [WORDSIZE-1:0] in_rs2_val,
    input  logic [WORDSIZE-1:0] in_imm,
    input  logic [REGADDR-1:0]  in_rs1_addr,
    input  logic [REGADDR-1:0]  in_rs2_addr,
    input  logic [REGADDR-1:0]  in_rd_addr,
    input  logic                in_use_imm,
    input  logic [ALU_OP_W-1:0] in_operation,
    input  logic                fwd_ex_valid,
    input  logic [REGADDR-1:0]  fwd_ex_rd,
    input  logic [WORDSIZE-1:0] fwd_ex_data,
    input  logic                fwd_wb_valid,
    input  logic [REGADDR-1:0]  fwd_wb_rd,
    input  logic [WORDSIZE-1:0] fwd_wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] input_a,
    output logic [WORDSIZE-1:0] input_b,
    output logic [ALU_OP_W-1:0] operation,
    output logic [REGADDR-1:0]  out_rd_addr
);

    logic                r_out_valid;
    logic [WORDSIZE-1:0] r_a;
    logic [WORDSIZE-1:0] r_b;
    logic [ALU_OP_W-1:0] r_op;
    logic [REGADDR-1:0]  r_rd;
    logic [REGADDR-1:0]  r_rs1;
    logic [REGADDR-1:0]  r_rs2;
    logic                r_use_imm;

    logic                w_accept;
    logic                w_out_free;
    logic [WORDSIZE-1:0] w_new_a;
    logic [WORDSIZE-1:0] w_new_b;
    logic [WORDSIZE-1:0] w_snp_out_a;
    logic [WORDSIZE-1:0] w_snp_out_b;

    logic                w_ld_valid;
    logic [WORDSIZE-1:0] w_ld_a;
    logic [WORDSIZE-1:0] w_ld_b;
    logic [ALU_OP_W-1:0] w_ld_op;
    logic [REGADDR-1:0]  w_ld_rd;
    logic [REGADDR-1:0]  w_ld_rs1;
    logic [REGADDR-1:0]  w_ld_rs2;
    logic                w_ld_use_imm;

    // Incoming op operands, resolved against this cycle's forwarding buses.
    operand_fwd_mux #(.WORDSIZE(WORDSIZE), .REGADDR(REGADDR)) u_fwd_new_a (
        .i_addr     (in_rs1_addr),
        .i_rf_val   (in_rs1_val),
        .i_use_imm  (1'b0),
        .i_imm      ('0),
        .i_ex_valid (fwd_ex_valid),
        .i_ex_rd    (fwd_ex_rd),
        .i_ex_data  (fwd_ex_data),
        .i_wb_valid (fwd_wb_valid),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_value    (w_new_a)
    );

    operand_fwd_mux #(.WORDSIZE(WORDSIZE), .REGADDR(REGADDR)) u_fwd_new_b (
        .i_addr     (in_rs2_addr),
        .i_rf_val   (in_rs2_val),
        .i_use_imm  (in_use_imm),
        .i_imm      (in_imm),
        .i_ex_valid (fwd_ex_valid),
        .i_ex_rd    (fwd_ex_rd),
        .i_ex_data  (fwd_ex_data),
        .i_wb_valid (fwd_wb_valid),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_value    (w_new_b)
    );

    // Held output entry snoops the buses so a stalled op sees late results.
    operand_fwd_mux #(.WORDSIZE(WORDSIZE), .REGADDR(REGADDR)) u_snp_out_a (
        .i_addr     (r_rs1),
        .i_rf_val   (r_a),
        .i_use_imm  (1'b0),
        .i_imm      ('0),
        .i_ex_valid (fwd_ex_valid),
        .i_ex_rd    (fwd_ex_rd),
        .i_ex_data  (fwd_ex_data),
        .i_wb_valid (fwd_wb_valid),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_value    (w_snp_out_a)
    );

    operand_fwd_mux #(.WORDSIZE(WORDSIZE), .REGADDR(REGADDR)) u_snp_out_b (
        .i_addr     (r_rs2),
        .i_rf_val   (r_b),
        .i_use_imm  (r_use_imm),
        .i_imm      (r_b),
        .i_ex_valid (fwd_ex_valid),
        .i_ex_rd    (fwd_ex_rd),
        .i_ex_data  (fwd_ex_data),
        .i_wb_valid (fwd_wb_valid),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_value    (w_snp_out_b)
    );

    assign w_out_free = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready && !flush;

`ifdef ALU_DISPATCH_SKID_EN
    logic                r_skid_valid;
    logic [WORDSIZE-1:0] r_skid_a;
    logic [WORDSIZE-1:0] r_skid_b;
    logic [ALU_OP_W-1:0] r_skid_op;
    logic [REGADDR-1:0]  r_skid_rd;
    logic [REGADDR-1:0]  r_skid_rs1;
    logic [REGADDR-1:0]  r_skid_rs2;
    logic                r_skid_use_imm;
    logic [WORDSIZE-1:0] w_snp_skid_a;
    logic [WORDSIZE-1:0] w_snp_skid_b;

    operand_fwd_mux #(.WORDSIZE(WORDSIZE), .REGADDR(REGADDR)) u_snp_skid_a (
        .i_addr     (r_skid_rs1),
        .i_rf_val   (r_skid_a),
        .i_use_imm  (1'b0),
        .i_imm      ('0),
        .i_ex_valid (fwd_ex_valid),
        .i_ex_rd    (fwd_ex_rd),
        .i_ex_data  (fwd_ex_data),
        .i_wb_valid (fwd_wb_valid),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_value    (w_snp_skid_a)
    );

    operand_fwd_mux #(.WORDSIZE(WORDSIZE), .REGADDR(REGADDR)) u_snp_skid_b (
        .i_addr     (r_skid_rs2),
        .i_rf_val   (r_skid_b),
        .i_use_imm  (r_skid_use_imm),
        .i_imm      (r_skid_b),
        .i_ex_valid (fwd_ex_valid),
        .i_ex_rd    (fwd_ex_rd),
        .i_ex_data  (fwd_ex_data),
        .i_wb_valid (fwd_wb_valid),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_value    (w_snp_skid_b)
    );

    // Ready depends only on skid occupancy, so it never combinationally follows out_ready.
    assign in_ready = reset_n && !r_skid_valid;

    // The skid entry is older than any new arrival, so it has first claim on the output slot.
    assign w_ld_valid   = r_skid_valid || w_accept;
    assign w_ld_a       = r_skid_valid ? w_snp_skid_a   : w_new_a;
    assign w_ld_b       = r_skid_valid ? w_snp_skid_b   : w_new_b;
    assign w_ld_op      = r_skid_valid ? r_skid_op      : in_operation;
    assign w_ld_rd      = r_skid_valid ? r_skid_rd      : in_rd_addr;
    assign w_ld_rs1     = r_skid_valid ? r_skid_rs1     : in_rs1_addr;
    assign w_ld_rs2     = r_skid_valid ? r_skid_rs2     : in_rs2_addr;
    assign w_ld_use_imm = r_skid_valid ? r_skid_use_imm : in_use_imm;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_skid_valid   <= 1'b0;
            r_skid_a       <= '0;
            r_skid_b       <= '0;
            r_skid_op      <= ALU_ADD;
            r_skid_rd      <= '0;
            r_skid_rs1     <= '0;
            r_skid_rs2     <= '0;
            r_skid_use_imm <= 1'b0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_out_free) begin
                r_skid_valid <= 1'b0;
            end else begin
                r_skid_a <= w_snp_skid_a;
                r_skid_b <= w_snp_skid_b;
            end
        end else if (w_accept && !w_out_free) begin
            r_skid_valid   <= 1'b1;
            r_skid_a       <= w_new_a;
            r_skid_b       <= w_new_b;
            r_skid_op      <= in_operation;
            r_skid_rd      <= in_rd_addr;
            r_skid_rs1     <= in_rs1_addr;
            r_skid_rs2     <= in_rs2_addr;
            r_skid_use_imm <= in_use_imm;
        end
    end
`else
    assign in_ready = reset_n && w_out_free;

    assign w_ld_valid   = w_accept;
    assign w_ld_a       = w_new_a;
    assign w_ld_b       = w_new_b;
    assign w_ld_op      = in_operation;
    assign w_ld_rd      = in_rd_addr;
    assign w_ld_rs1     = in_rs1_addr;
    assign w_ld_rs2     = in_rs2_addr;
    assign w_ld_use_imm = in_use_imm;
`endif

    // Data registers only change on a load or a stalled snoop; idle cycles keep the last op visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= ALU_ADD;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_use_imm   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_out_free) begin
            r_out_valid <= w_ld_valid;
            if (w_ld_valid) begin
                r_a       <= w_ld_a;
                r_b       <= w_ld_b;
                r_op      <= w_ld_op;
                r_rd      <= w_ld_rd;
                r_rs1     <= w_ld_rs1;
                r_rs2     <= w_ld_rs2;
                r_use_imm <= w_ld_use_imm;
            end
        end else begin
            r_a <= w_snp_out_a;
            r_b <= w_snp_out_b;
        end
    end

    assign out_valid   = r_out_valid;
    assign input_a     = r_a;
    assign input_b     = r_b;
    assign operation   = r_op;
    assign out_rd_addr = r_rd;

endmodule

// File: tb/tb_alu_operand_dispatch.sv
// Bench for alu_operand_dispatch: directed vector table, hand-written stall/flush/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_alu_operand_dispatch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_rs1_val;
    logic [63:0] in_rs2_val;
    logic [63:0] in_imm;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [4:0]  in_rd_addr;
    logic        in_use_imm;
    logic [2:0]  in_operation;
    logic        fwd_ex_valid;
    logic [4:0]  fwd_ex_rd;
    logic [63:0] fwd_ex_data;
    logic        fwd_wb_valid;
    logic [4:0]  fwd_wb_rd;
    logic [63:0] fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] input_a;
    logic [63:0] input_b;
    logic [2:0]  operation;
    logic [4:0]  out_rd_addr;

    int total = 0;
    int bad   = 0;

    alu_operand_dispatch dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1_val   (in_rs1_val),
        .in_rs2_val   (in_rs2_val),
        .in_imm       (in_imm),
        .in_rs1_addr  (in_rs1_addr),
        .in_rs2_addr  (in_rs2_addr),
        .in_rd_addr   (in_rd_addr),
        .in_use_imm   (in_use_imm),
        .in_operation (in_operation),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_rd    (fwd_wb_rd),
        .fwd_wb_data  (fwd_wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .input_a      (input_a),
        .input_b      (input_b),
        .operation    (operation),
        .out_rd_addr  (out_rd_addr)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    typedef struct {
        logic [63:0] rs1_val, rs2_val, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        use_imm;
        logic [2:0]  op;
        logic        ex_v;
        logic [4:0]  ex_rd;
        logic [63:0] ex_d;
        logic        wb_v;
        logic [4:0]  wb_rd;
        logic [63:0] wb_d;
        logic [63:0] exp_a, exp_b;
    } vec_t;

    typedef struct {
        logic [63:0] a, b;
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic        imm;
    } ent_t;

    vec_t vecs[6];
    ent_t q[$];
    ent_t shown;
    ent_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        flush        = 1'b0;
        in_rs1_val   = '0;
        in_rs2_val   = '0;
        in_imm       = '0;
        in_rs1_addr  = '0;
        in_rs2_addr  = '0;
        in_rd_addr   = '0;
        in_use_imm   = 1'b0;
        in_operation = '0;
        fwd_ex_valid = 1'b0;
        fwd_ex_rd    = '0;
        fwd_ex_data  = '0;
        fwd_wb_valid = 1'b0;
        fwd_wb_rd    = '0;
        fwd_wb_data  = '0;
    endtask

    task automatic set_op(input logic [63:0] v1, input logic [63:0] v2, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] rd, input logic [2:0] op);
        in_valid     = 1'b1;
        in_rs1_val   = v1;
        in_rs2_val   = v2;
        in_rs1_addr  = a1;
        in_rs2_addr  = a2;
        in_rd_addr   = rd;
        in_operation = op;
        in_use_imm   = 1'b0;
        in_imm       = '0;
    endtask

    // Forwarding rule: x0 never forwarded, EX/MEM beats MEM/WB beats the given value.
    function automatic logic [63:0] resolve(input logic [4:0] a, input logic [63:0] v);
        if (a != 5'd0 && fwd_ex_valid && fwd_ex_rd == a) return fwd_ex_data;
        if (a != 5'd0 && fwd_wb_valid && fwd_wb_rd == a) return fwd_wb_data;
        return v;
    endfunction

    initial begin
        logic exp_ready;
        logic acc;
        logic iss;

        // rs1_val, rs2_val, imm, rs1, rs2, rd, use_imm, op, ex_v, ex_rd, ex_d, wb_v, wb_rd, wb_d, exp_a, exp_b
        vecs[0] = '{64'h5, 64'h2, 64'h0, 5'd1, 5'd2, 5'd9, 1'b0, 3'b000,
                    1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h5, 64'h2};
        vecs[1] = '{64'h1, 64'h99, 64'h10, 5'd7, 5'd4, 5'd12, 1'b1, 3'b000,
                    1'b1, 5'd4, 64'hEE, 1'b0, 5'd0, 64'h0, 64'h1, 64'h10};
        vecs[2] = '{64'h11, 64'h22, 64'h0, 5'd3, 5'd5, 5'd3, 1'b0, 3'b001,
                    1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB, 64'hAA, 64'h22};
        vecs[3] = '{64'h33, 64'h44, 64'h0, 5'd0, 5'd0, 5'd1, 1'b0, 3'b010,
                    1'b1, 5'd0, 64'hCC, 1'b1, 5'd0, 64'hDD, 64'h33, 64'h44};
        vecs[4] = '{64'h7, 64'h8, 64'h0, 5'd9, 5'd6, 5'd31, 1'b0, 3'b100,
                    1'b0, 5'd6, 64'h66, 1'b1, 5'd6, 64'h55, 64'h7, 64'h55};
        vecs[5] = '{64'h1, 64'h2, 64'h0, 5'd2, 5'd2, 5'd17, 1'b0, 3'b111,
                    1'b1, 5'd2, 64'hF0, 1'b1, 5'd1, 64'h0F, 64'hF0, 64'hF0};

        idle();
        out_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_input_a", input_a, 0);
        chk("rst_input_b", input_b, 0);
        chk("rst_operation", operation, 0);
        chk("rst_rd", out_rd_addr, 0);
        chk("rst_in_ready", in_ready, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            in_valid     = 1'b1;
            out_ready    = 1'b1;
            in_rs1_val   = vecs[i].rs1_val;
            in_rs2_val   = vecs[i].rs2_val;
            in_imm       = vecs[i].imm;
            in_rs1_addr  = vecs[i].rs1;
            in_rs2_addr  = vecs[i].rs2;
            in_rd_addr   = vecs[i].rd;
            in_use_imm   = vecs[i].use_imm;
            in_operation = vecs[i].op;
            fwd_ex_valid = vecs[i].ex_v;
            fwd_ex_rd    = vecs[i].ex_rd;
            fwd_ex_data  = vecs[i].ex_d;
            fwd_wb_valid = vecs[i].wb_v;
            fwd_wb_rd    = vecs[i].wb_rd;
            fwd_wb_data  = vecs[i].wb_d;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_a", i), input_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), input_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_op", i), operation, vecs[i].op);
            chk($sformatf("vec%0d_rd", i), out_rd_addr, vecs[i].rd);
            idle();
        end
        @(posedge clock);
        #1;
        chk("vec_drain", out_valid, 0);
        chk("vec_hold_a", input_a, 64'hF0);

        // Stall with two ops offered; a late writeback must reach the waiting op.
        @(negedge clock);
        idle();
        out_ready = 1'b0;
        set_op(64'h1000, 64'h2000, 5'd1, 5'd2, 5'd10, 3'b000);
`ifdef ALU_DISPATCH_SKID_EN
        @(posedge clock);
        @(negedge clock);
        set_op(64'h3000, 64'h4000, 5'd3, 5'd4, 5'd11, 3'b001);
        #1;
        chk("t5_ready_x", in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("t5_ready_full", in_ready, 0);
        chk("t5_head_a", input_a, 64'h1000);
        fwd_wb_valid = 1'b1;
        fwd_wb_rd    = 5'd4;
        fwd_wb_data  = 64'h77;
        @(posedge clock);
        @(negedge clock);
        fwd_wb_valid = 1'b0;
        chk("t5_x_a", input_a, 64'h1000);
        chk("t5_x_b", input_b, 64'h2000);
        chk("t5_x_rd", out_rd_addr, 10);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("t5_y_valid", out_valid, 1);
        chk("t5_y_a", input_a, 64'h3000);
        chk("t5_y_b", input_b, 64'h77);
        chk("t5_y_rd", out_rd_addr, 11);
        chk("t5_ready_again", in_ready, 1);
`else
        @(posedge clock);
        @(negedge clock);
        set_op(64'h3000, 64'h4000, 5'd3, 5'd4, 5'd11, 3'b001);
        fwd_wb_valid = 1'b1;
        fwd_wb_rd    = 5'd2;
        fwd_wb_data  = 64'h77;
        #1;
        chk("t5_ready_stall", in_ready, 0);
        @(posedge clock);
        @(negedge clock);
        fwd_wb_valid = 1'b0;
        out_ready    = 1'b1;
        #1;
        chk("t5_ready_release", in_ready, 1);
        chk("t5_x_a", input_a, 64'h1000);
        chk("t5_x_b", input_b, 64'h77);
        chk("t5_x_rd", out_rd_addr, 10);
        @(posedge clock);
        #1;
        chk("t5_y_valid", out_valid, 1);
        chk("t5_y_a", input_a, 64'h3000);
        chk("t5_y_b", input_b, 64'h4000);
        chk("t5_y_rd", out_rd_addr, 11);
`endif
        idle();
        @(posedge clock);
        #1;
        chk("t5_drain", out_valid, 0);

        // Fill the stage under stall, then flush with a new op offered.
        @(negedge clock);
        out_ready = 1'b0;
        set_op(64'h5, 64'h6, 5'd1, 5'd2, 5'd3, 3'b000);
`ifdef ALU_DISPATCH_SKID_EN
        @(posedge clock);
        @(negedge clock);
        set_op(64'h7, 64'h8, 5'd1, 5'd2, 5'd4, 3'b000);
`endif
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("t6_full", in_ready, 0);
        set_op(64'h9, 64'hA, 5'd1, 5'd2, 5'd5, 3'b000);
        flush = 1'b1;
        @(posedge clock);
        #1;
        chk("t6_flush_valid", out_valid, 0);
        chk("t6_flush_ready", in_ready, 1);
        idle();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("t6_quiet%0d", k), out_valid, 0);
        end

        // Asynchronous reset while an op is presented.
        @(negedge clock);
        out_ready = 1'b0;
        set_op(64'h1234, 64'h5678, 5'd1, 5'd2, 5'd7, 3'b011);
        @(posedge clock);
        #1;
        chk("t1_loaded", out_valid, 1);
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_valid", out_valid, 0);
        chk("t1_a", input_a, 0);
        chk("t1_b", input_b, 0);
        chk("t1_op", operation, 0);
        chk("t1_ready", in_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("t1_ready_rel", in_ready, 1);
        @(posedge clock);
        #1;
        chk("t1_dropped", out_valid, 0);

        // Randomized traffic against a FIFO model of the stage.
        q.delete();
        shown = '{64'h0, 64'h0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            chk("rnd_valid", out_valid, q.size() > 0);
            chk("rnd_a", input_a, shown.a);
            chk("rnd_b", input_b, shown.b);
            chk("rnd_op", operation, shown.op);
            chk("rnd_rd", out_rd_addr, shown.rd);
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 29) == 0);
            in_rs1_addr  = 5'($urandom_range(0, 3));
            in_rs2_addr  = 5'($urandom_range(0, 3));
            in_rd_addr   = 5'($urandom_range(0, 31));
            in_rs1_val   = {$urandom, $urandom};
            in_rs2_val   = {$urandom, $urandom};
            in_imm       = {$urandom, $urandom};
            in_use_imm   = ($urandom_range(0, 2) == 0);
            in_operation = 3'($urandom_range(0, 7));
            fwd_ex_valid = ($urandom_range(0, 1) != 0);
            fwd_ex_rd    = 5'($urandom_range(0, 3));
            fwd_ex_data  = {$urandom, $urandom};
            fwd_wb_valid = ($urandom_range(0, 1) != 0);
            fwd_wb_rd    = 5'($urandom_range(0, 3));
            fwd_wb_data  = {$urandom, $urandom};
            #1;
`ifdef ALU_DISPATCH_SKID_EN
            exp_ready = (q.size() < 2);
`else
            exp_ready = (q.size() == 0) || out_ready;
`endif
            chk("rnd_in_ready", in_ready, exp_ready);
            acc = in_valid && exp_ready && !flush;
            iss = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                foreach (q[k]) begin
                    q[k].a = resolve(q[k].rs1, q[k].a);
                    if (!q[k].imm) q[k].b = resolve(q[k].rs2, q[k].b);
                end
                if (iss) void'(q.pop_front());
                if (acc) begin
                    e.a   = resolve(in_rs1_addr, in_rs1_val);
                    e.b   = in_use_imm ? in_imm : resolve(in_rs2_addr, in_rs2_val);
                    e.op  = in_operation;
                    e.rd  = in_rd_addr;
                    e.rs1 = in_rs1_addr;
                    e.rs2 = in_rs2_addr;
                    e.imm = in_use_imm;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) shown = q[0];
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
